multi_cycle_controller: RTL
===========================

Name: multi_cycle_controller

Overview:
- Moore/Mealy FSM that sequences the multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut/MDR registers.
- Supports R-type, addi, slti, lw, sw, beq, j and jal, using the same opcode values and AluOp encoding as the single-cycle core.
- Each memory access waits on a ready handshake, with a bounded wait. The block also reports instruction retirement and illegal opcodes.

Parameters:
- WAIT_LIMIT, 16: maximum number of cycles in one memory state with mem_ready low. 0 disables the timeout.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- OpCode  in  6  IR[31:26]; stable after FETCH completes
- mem_ready  in  1  memory has completed the current read or write this cycle
- PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg, RegDst, RegWrite, AluSrcA, JalWrite  out  1 each  datapath controls
- AluSrcB  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- AluOp  out  2  00=add, 01=sub, 10=slt, 11=decode funct
- PcSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28],addr,00}
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- bus_error  out  1  sticky; set on memory timeout, cleared only by rst

Behaviour:
- Reset: while rst=1, every output is forced to 0, state<=FETCH, wait counter<=0, bus_error<=0. The first cycle after release is FETCH.
- Any output not listed for a state is 0.
- State encoding: 4-bit. State actions and transitions:
  - FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00, PcSrc=00. IrWrite and PcWrite are asserted only in the cycle where mem_ready=1. mem_ready=1 -> DECODE; otherwise stay.
  - DECODE: AluSrcA=0, AluSrcB=11, AluOp=00 (computes the branch target).
    - R-type -> R_EXEC; addi/slti -> IMM_EXEC; lw/sw -> MEM_ADDR; beq -> BRANCH; j -> JUMP; jal -> JAL.
    - Any other opcode: illegal_op=1, instr_done=1, -> FETCH.
  - MEM_ADDR: AluSrcA=1, AluSrcB=10, AluOp=00. lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ: MemRead=1, IorD=1. mem_ready -> MEM_WB.
  - MEM_WB: RegWrite=1, MemToReg=1, RegDst=0, instr_done=1 -> FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1. mem_ready -> instr_done=1, FETCH.
  - R_EXEC: AluSrcA=1, AluSrcB=00, AluOp=11 -> R_WB.
  - R_WB: RegDst=1, RegWrite=1, instr_done=1 -> FETCH.
  - IMM_EXEC: AluSrcA=1, AluSrcB=10; AluOp=00 for addi, 10 for slti -> IMM_WB.
  - IMM_WB: RegWrite=1, RegDst=0, MemToReg=0, instr_done=1 -> FETCH.
  - BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PcWriteCond=1, PcSrc=01, instr_done=1 -> FETCH.
  - JUMP: PcWrite=1, PcSrc=10, instr_done=1 -> FETCH.
  - JAL: PcWrite=1, PcSrc=10, RegWrite=1, JalWrite=1, instr_done=1 -> FETCH. PC+4 was already written in FETCH and goes to $31.
- Cycle counts with mem_ready tied to 1:
  - beq, j, jal: 3 cycles
  - R-type, addi, slti, sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle adds 1 cycle.
- Wait counter:
  - Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Cleared on leaving any state or when mem_ready=1.
  - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT: bus_error<=1, abandon the access, go to FETCH. No IrWrite, PcWrite, RegWrite or instr_done is issued, so PC is unchanged and the same fetch is retried.
- Simultaneous events: mem_ready=1 in the same cycle the counter hits the limit -> the access completes normally and no error is raised.
- rst asserted mid-instruction aborts the instruction with no partial commit. All write enables are already 0 while rst=1.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants (RT, addi, slti, beq, j, jal, lw, sw)
  - state enum
  - AluOp, AluSrcB and PcSrc encodings
- Single module, no sub-module. The output decode stays a combinational always block keyed on state.

Test Plan:
- rst=1 for 2 cycles with mem_ready=1 -> all outputs 0. Release -> FETCH with MemRead=1, IrWrite=1, PcWrite=1.
- add (OpCode 000000), mem_ready=1 -> 4 cycles. R_EXEC shows AluOp=11, AluSrcB=00. R_WB shows RegDst=1, RegWrite=1, instr_done=1.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ -> MemRead and IorD held for 4 cycles; MEM_WB has MemToReg=1, RegWrite=1; 8 cycles total.
- beq (000100) then jal (000011) -> BRANCH has PcWriteCond=1, PcSrc=01, AluOp=01. JAL has PcWrite=1, PcSrc=10, JalWrite=1, RegWrite=1. 3 cycles each.
- OpCode 111111 -> illegal_op and instr_done pulse in DECODE, return to FETCH, no write enables asserted.
- WAIT_LIMIT=4, mem_ready=0 in FETCH -> bus_error rises after 4 wait cycles, FSM re-enters FETCH, no IrWrite/PcWrite. Sticky until rst.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the supported opcodes, the FSM state type, the encodings of the
// AluOp / AluSrcB / PcSrc control fields, and the DECODE dispatch function.
package mc_ctrl_pkg;

  // Opcodes (IR[31:26]), identical to the single-cycle core.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_IMM_EXEC  = 4'd8,
    S_IMM_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_SLT   = 2'b10,
    ALU_FUNCT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_t;

  // State entered after DECODE; S_FETCH marks an unsupported opcode.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:       return S_R_EXEC;
      OP_ADDI,
      OP_SLTI:        return S_IMM_EXEC;
      OP_LW,
      OP_SW:          return S_MEM_ADDR;
      OP_BEQ:         return S_BRANCH;
      OP_J:           return S_JUMP;
      OP_JAL:         return S_JAL;
      default:        return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM.
// Sequences a shared instruction/data memory datapath (IR, A, B, ALUOut, MDR)
// through FETCH / DECODE / execute / memory / write-back states.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   OpCode          IR[31:26], stable once FETCH has completed
//   mem_ready       memory finished the current access this cycle
//   PcWrite .. JalWrite, AluSrcB, AluOp, PcSrc   datapath controls
//   instr_done      pulse on the last cycle of each instruction
//   illegal_op      pulse in DECODE for an unsupported opcode
//   bus_error       sticky memory-timeout flag, cleared only by rst
module multi_cycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic       mem_ready,
  output logic       PcWrite,
  output logic       PcWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IrWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic       JalWrite,
  output logic [1:0] AluSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] PcSrc,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error
);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_bus_error;

  logic w_mem_state;
  logic w_timeout;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE);

  // The counter holds the number of wait cycles already spent; the access is
  // abandoned only if memory is still not ready once that number hits the
  // limit, so a late mem_ready on the limit cycle still completes normally.
  assign w_timeout = (WAIT_LIMIT != 0) && w_mem_state && !mem_ready &&
                     (r_wait_cnt == CNT_W'(WAIT_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else if (w_timeout) begin
      r_bus_error <= 1'b1;
      r_wait_cnt  <= '0;
      r_state     <= S_FETCH;
    end else begin
      r_wait_cnt <= (w_mem_state && !mem_ready) ? r_wait_cnt + 1'b1 : '0;
      case (r_state)
        S_FETCH:     if (mem_ready) r_state <= S_DECODE;
        S_DECODE:    r_state <= decode_target(OpCode);
        S_MEM_ADDR:  r_state <= (OpCode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:    r_state <= S_R_WB;
        S_IMM_EXEC:  r_state <= S_IMM_WB;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode. IrWrite/PcWrite in FETCH and instr_done in MEM_WRITE
  // depend on mem_ready so nothing commits before the access completes.
  // A timeout cycle always has mem_ready low, so it commits nothing either.
  always_comb begin
    PcWrite     = 1'b0;
    PcWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IrWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    JalWrite    = 1'b0;
    AluSrcB     = SRCB_REG;
    AluOp       = ALU_ADD;
    PcSrc       = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    bus_error   = 1'b0;
    if (!rst) begin
      bus_error = r_bus_error;
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          AluSrcB = SRCB_FOUR;
          IrWrite = mem_ready;
          PcWrite = mem_ready;
        end
        S_DECODE: begin
          AluSrcB = SRCB_IMM_SH2;
          if (decode_target(OpCode) == S_FETCH) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEM_ADDR: begin
          AluSrcA = 1'b1;
          AluSrcB = SRCB_IMM;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXEC: begin
          AluSrcA = 1'b1;
          AluOp   = ALU_FUNCT;
        end
        S_R_WB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_IMM_EXEC: begin
          AluSrcA = 1'b1;
          AluSrcB = SRCB_IMM;
          AluOp   = (OpCode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_IMM_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          AluSrcA     = 1'b1;
          AluOp       = ALU_SUB;
          PcWriteCond = 1'b1;
          PcSrc       = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PcWrite    = 1'b1;
          PcSrc      = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_JAL: begin
          PcWrite    = 1'b1;
          PcSrc      = PCSRC_JUMP;
          RegWrite   = 1'b1;
          JalWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
